// File: rtl/datamem_dump_reader_pkg.sv
// Shared debug-unit definitions: dump FSM encoding, stream byte order and
// default widths common to the UART TX path and the memory debug port.
package datamem_dump_reader_pkg;

  localparam int NB_REG_DEF      = 32;
  localparam int NB_BYTE_DEF     = 8;
  localparam int NB_DBG_ADDR_DEF = 16;

  // Words leave on the stream most-significant byte first.
  localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

  // Bits needed to index 'value' items; never less than one.
  function automatic int clogb2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/datamem_dump_reader.sv
// Sweeps data-memory words 0..N_WORDS-1 over the debug read port and
// serializes each word onto a valid/ready byte stream for the debug UART.
//
// state   | meaning
// IDLE    | waiting for i_start, outputs quiet
// READ    | read enable + address of current word to memory
// CAPTURE | read data arrives, loaded into the shift register
// SEND    | bytes offered on the stream until the whole word is accepted
// DONE    | one-cycle completion pulse
module datamem_dump_reader
  import datamem_dump_reader_pkg::*;
#(
  parameter int NB_REG      = NB_REG_DEF,
  parameter int NB_BYTE     = NB_BYTE_DEF,
  parameter int NB_DBG_ADDR = NB_DBG_ADDR_DEF,
  parameter int N_WORDS     = 2048
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic [NB_DBG_ADDR-1:0] o_debug_datamem_addr,
  output logic                   o_debug_datamem_re,
  input  logic [NB_REG-1:0]      i_debug_datamem_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int N_BYTES = NB_REG / NB_BYTE;
  localparam int NB_IDX  = clogb2(N_BYTES);

  // With N_WORDS == 2**NB_DBG_ADDR this is all-ones, so the sweep ends
  // before the counter could wrap back to zero.
  localparam logic [NB_DBG_ADDR-1:0] LAST_ADDR = NB_DBG_ADDR'(N_WORDS - 1);
  localparam logic [NB_IDX-1:0]      LAST_IDX  = NB_IDX'(N_BYTES - 1);

  dump_state_e state, state_next;

  logic [NB_DBG_ADDR-1:0] word_cnt;
  logic [NB_REG-1:0]      shift_reg;
  logic [NB_REG-1:0]      shift_next;
  logic [NB_BYTE-1:0]     out_byte;
  logic [NB_IDX-1:0]      byte_idx;
  logic                   byte_accept;
  logic                   last_byte;
  logic                   last_word;

  if (BYTE_ORDER_MSB_FIRST) begin : g_msb_first
    assign out_byte   = shift_reg[NB_REG-1 -: NB_BYTE];
    assign shift_next = shift_reg << NB_BYTE;
  end else begin : g_lsb_first
    assign out_byte   = shift_reg[NB_BYTE-1:0];
    assign shift_next = shift_reg >> NB_BYTE;
  end

  assign byte_accept = (state == ST_SEND) && i_tx_ready;
  assign last_byte   = (byte_idx == LAST_IDX);
  assign last_word   = (word_cnt == LAST_ADDR);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next           = state;
    o_debug_datamem_re   = 1'b0;
    o_debug_datamem_addr = '0;
    o_tx_valid           = 1'b0;
    o_busy               = 1'b1;
    o_done               = 1'b0;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        o_debug_datamem_re   = 1'b1;
        o_debug_datamem_addr = word_cnt;
        state_next           = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = ST_SEND;
      end
      ST_SEND: begin
        o_tx_valid = 1'b1;
        if (byte_accept && last_byte) begin
          state_next = last_word ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        o_busy     = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Data only shows while valid so the stream is quiet outside SEND.
  assign o_tx_data = o_tx_valid ? out_byte : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_cnt  <= '0;
      shift_reg <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            word_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          shift_reg <= i_debug_datamem_data;
          byte_idx  <= '0;
        end
        ST_SEND: begin
          if (byte_accept) begin
            shift_reg <= shift_next;
            byte_idx  <= byte_idx + NB_IDX'(1);
            if (last_byte && !last_word) begin
              word_cnt <= word_cnt + NB_DBG_ADDR'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/datamem_dump_reader.md
# datamem_dump_reader

Debug-side consumer of the data-memory debug read port of the memory-access stage. On request it sweeps data-memory words 0..N_WORDS-1 through the second memory port and serializes each 32-bit word into bytes on a valid/ready byte stream feeding the debug UART transmitter. It sits in the debug unit, between the pipeline's debug memory port and the UART TX path, and never touches the pipeline's own memory port.

## Interface
- NB_REG, 32, width of one data-memory word (multiple of NB_BYTE)
- NB_BYTE, 8, width of one stream byte
- NB_DBG_ADDR, 16, width of the debug word address
- N_WORDS, 2048, number of words dumped per request (1..2^NB_DBG_ADDR)

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clock
- i_start  in  1  one-cycle dump request; sampled only in IDLE
- o_debug_datamem_addr  out  NB_DBG_ADDR  word address to memory debug port
- o_debug_datamem_re  out  1  read enable to memory debug port
- i_debug_datamem_data  in  NB_REG  read data, valid the cycle after re
- o_tx_data  out  NB_BYTE  byte to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts byte this cycle
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle pulse after last byte accepted

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: outputs quiet; i_start=1 -> word counter=0, go READ.
- READ: o_debug_datamem_re=1, o_debug_datamem_addr=counter; go CAPTURE.
- CAPTURE: re=0; register i_debug_datamem_data into shift register, byte index=0; go SEND.
- SEND: o_tx_valid=1, o_tx_data = most-significant byte of shift register (MSB first). On valid&ready: shift left by NB_BYTE, index+1; after NB_REG/NB_BYTE-th byte: if counter==N_WORDS-1 go DONE, else counter+1, go READ.
- DONE: o_done=1 for one cycle; go IDLE.
- o_busy=1 in READ, CAPTURE, SEND, DONE.
- Byte accepted only on a clock edge with o_tx_valid&i_tx_ready; o_tx_data stable while valid and not ready; valid never drops without acceptance except on reset.
- i_start outside IDLE ignored (no queuing). i_start in the DONE cycle ignored.
- Counter NB_DBG_ADDR bits; N_WORDS=2^NB_DBG_ADDR ends on all-ones without wrap-induced extra pass.
- Memory content not retained between words; each word read exactly once.

## Timing
- Reset: state IDLE, all outputs 0 (addr 0, re 0, tx_data 0, valid 0, busy 0, done 0), counters 0.
- Reset mid-dump: abort immediately next edge; partial stream not resumed.
- Start to first o_tx_valid: 3 cycles (edge T accepts start, READ at T+1, CAPTURE T+2, SEND T+3).
- Per-word overhead: 2 non-SEND cycles (READ, CAPTURE) between last byte of word n and first byte of word n+1.
- With i_tx_ready tied high: N_WORDS*(2+NB_REG/NB_BYTE) cycles from first READ to DONE.
- o_done asserted the cycle after the final byte handshake.

## Structure
- Shared debug package: state encoding localparams, MSB-first byte-order constant, NB_BYTE, NB_DBG_ADDR defaults shared with the UART TX and memory debug port.
- Single module; no sub-module needed (shift-register serializer is inline).
- clogb2 for byte-index width from the common function include.

## Test plan
- Memory words 0..3 = 0x11223344, 0xAABBCCDD, 0x00000000, 0xFFFFFFFF, N_WORDS=4, ready=1 -> stream 11 22 33 44 AA BB CC DD 00 00 00 00 FF FF FF FF, done at cycle 3+24-... (exactly 24 cycles after first READ).
- Backpressure: ready toggles 1,0,0,1 pattern -> every byte held stable while valid&!ready, no byte duplicated or lost.
- i_start pulsed repeatedly during dump -> exactly one dump of N_WORDS words, busy high throughout.
- i_reset asserted during SEND of word 1 byte 2 -> next cycle all outputs 0, state IDLE; new start replays from address 0.
- Address check: re high exactly N_WORDS cycles per dump, addresses 0,1,...,N_WORDS-1 in order, each one cycle before capture.
- NB_DBG_ADDR=4, N_WORDS=16 -> last address 15, no 17th read, done pulse single cycle.
